uart_tx_ext: RTL

Parametrised successor UART transmitter for the serial-terminal design. It adds an internal transmit FIFO, runtime-selectable parity (none/even/odd/mark) and 1 or 2 stop bits. It sits between the AXI4-Stream byte producer (terminal/echo logic) and the txd pin. Oversampled prescale semantics are unchanged: bit time = prescale*8 clk cycles.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_sync_fifo.sv | 54 +++++
 rtl/uart_tx_ext.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and parity helper for the uart_tx_ext transmitter.
package uart_pkg;

  localparam logic [1:0] PARITY_NONE = 2'b00;
  localparam logic [1:0] PARITY_EVEN = 2'b01;
  localparam logic [1:0] PARITY_ODD  = 2'b10;
  localparam logic [1:0] PARITY_MARK = 2'b11;

  localparam logic STOP_ONE = 1'b0;
  localparam logic STOP_TWO = 1'b1;

  localparam int MAX_DATA_WIDTH = 9;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  // Unused upper data bits must be zero so they do not disturb the XOR.
  function automatic logic parity_bit(input logic [MAX_DATA_WIDTH-1:0] data,
                                      input logic [1:0]                mode);
    logic r;
    case (mode)
      PARITY_EVEN: r = ^data;
      PARITY_ODD:  r = ~^data;
      PARITY_MARK: r = 1'b1;
      default:     r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Register-array synchronous FIFO with first-word-fall-through read data.
module uart_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty,
  output logic [AW:0]      o_count
);

  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rdata   = r_mem[r_rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wdata;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_count <= r_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
    end
  end

endmodule

// File: rtl/uart_tx_ext.sv
// FIFO-buffered UART transmitter with runtime parity mode, 1/2 stop bits and
// prescale*8 cycle bit time; frame config is latched when a word is popped.
module uart_tx_ext
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WIDTH  = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic                  txd,
  output logic                  busy,
  output logic [CNT_WIDTH-1:0]  fifo_count,
  input  logic [15:0]           prescale,
  input  logic [1:0]            parity_mode,
  input  logic                  stop_bits
);

  localparam int IDX_W = $clog2(DATA_WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  tx_state_t             r_state;
  tx_state_t             w_state_next;
  logic [18:0]           r_timer;
  logic [15:0]           r_frame_prescale;
  logic [1:0]            r_frame_parity;
  logic                  r_frame_stop;
  logic                  r_stop_cnt;
  logic                  r_parity;
  logic                  r_txd;
  logic                  r_busy;
  logic [DATA_WIDTH-1:0] r_data;
  logic [IDX_W-1:0]      r_bit_idx;
  logic [IDX_W-1:0]      w_bit_idx_next;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_tick;
  logic                  w_stop_last;
  logic                  w_reload;
  logic                  w_txd_next;
  logic                  w_busy_next;
  logic [DATA_WIDTH-1:0] w_fifo_rdata;
  logic [CNT_WIDTH-1:0]  w_count;
  logic [CNT_WIDTH-1:0]  w_count_next;
  logic [15:0]           w_prescale_clamped;
  logic [18:0]           w_load_timer;

  assign s_axis_tready      = !w_full;
  assign txd                = r_txd;
  assign busy               = r_busy;
  assign fifo_count         = w_count;
  assign w_push             = s_axis_tvalid && !w_full;
  assign w_tick             = (r_timer == 19'd0);
  assign w_stop_last        = (r_frame_stop == STOP_ONE) || r_stop_cnt;
  assign w_prescale_clamped = (prescale == 16'd0) ? 16'd1 : prescale;
  assign w_load_timer       = w_pop ? ({w_prescale_clamped, 3'b000} - 19'd1)
                                    : ({r_frame_prescale, 3'b000} - 19'd1);
  assign w_reload           = w_pop || (w_tick && (w_state_next != ST_IDLE));
  assign w_count_next       = w_count + CNT_WIDTH'(w_push) - CNT_WIDTH'(w_pop);

  uart_sync_fifo #(
    .WIDTH (DATA_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_wdata (s_axis_tdata),
    .i_pop   (w_pop),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A pop happens from IDLE or at the end of STOP, so back-to-back frames have no gap.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_next = ST_START;
          w_pop        = 1'b1;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_START: begin
        if (w_tick) w_state_next = ST_DATA;
        else        w_state_next = ST_START;
      end
      ST_DATA: begin
        if (w_tick && (r_bit_idx == LAST_IDX)) begin
          w_state_next = (r_frame_parity != PARITY_NONE) ? ST_PARITY : ST_STOP;
        end else begin
          w_state_next = ST_DATA;
        end
      end
      ST_PARITY: begin
        if (w_tick) w_state_next = ST_STOP;
        else        w_state_next = ST_PARITY;
      end
      ST_STOP: begin
        if (w_tick && w_stop_last) begin
          if (!w_empty) begin
            w_state_next = ST_START;
            w_pop        = 1'b1;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_state_next = ST_STOP;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    w_bit_idx_next = '0;
    if (r_state == ST_DATA) begin
      w_bit_idx_next = w_tick ? (r_bit_idx + IDX_W'(1)) : r_bit_idx;
    end else begin
      w_bit_idx_next = '0;
    end
    w_txd_next = 1'b1;
    case (w_state_next)
      ST_IDLE:   w_txd_next = 1'b1;
      ST_START:  w_txd_next = 1'b0;
      ST_DATA:   w_txd_next = r_data[w_bit_idx_next];
      ST_PARITY: w_txd_next = r_parity;
      ST_STOP:   w_txd_next = 1'b1;
      default:   w_txd_next = 1'b1;
    endcase
    w_busy_next = (w_state_next != ST_IDLE) || (w_count_next != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timer          <= 19'd0;
      r_frame_prescale <= 16'd1;
      r_frame_parity   <= PARITY_NONE;
      r_frame_stop     <= STOP_ONE;
      r_stop_cnt       <= 1'b0;
      r_parity         <= 1'b0;
      r_data           <= '0;
      r_bit_idx        <= '0;
      r_txd            <= 1'b1;
      r_busy           <= 1'b0;
    end else begin
      if (w_pop) begin
        r_data           <= w_fifo_rdata;
        r_parity         <= parity_bit(MAX_DATA_WIDTH'(w_fifo_rdata), parity_mode);
        r_frame_prescale <= w_prescale_clamped;
        r_frame_parity   <= parity_mode;
        r_frame_stop     <= stop_bits;
      end
      if (w_reload) begin
        r_timer <= w_load_timer;
      end else if (r_timer != 19'd0) begin
        r_timer <= r_timer - 19'd1;
      end
      if (r_state != ST_STOP) begin
        r_stop_cnt <= 1'b0;
      end else if (w_tick) begin
        r_stop_cnt <= 1'b1;
      end
      r_bit_idx <= w_bit_idx_next;
      r_txd     <= w_txd_next;
      r_busy    <= w_busy_next;
    end
  end

endmodule
